// File: rtl/adc_servo_sequencer.sv
// ADC sample sequencer: periodic tick, windowed averaging with ready/ack handshake,
// and prioritised servo-case selection (rest > processor write > auto from average).
module adc_servo_sequencer #(
    parameter int SAMPLE_PERIOD = 500,
    parameter int AVG_LOG2      = 3,
    parameter bit AUTO_EN       = 1'b1
) (
    input  logic       clock,
    input  logic       ctrl_reset,
    input  logic [7:0] JA,
    input  logic       rest,
    input  logic       active,
    input  logic       cpu_ack,
    input  logic       cpu_case_we,
    input  logic [2:0] cpu_case,
    output logic [7:0] sample_avg,
    output logic       sample_ready,
    output logic       overrun,
    output logic [2:0] servo_case,
    output logic       busy
);

    localparam int CNT_W = $clog2(SAMPLE_PERIOD);
    localparam int ACC_W = 8 + AVG_LOG2;
    localparam int N_W   = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_PERIOD - 1);
    localparam logic [N_W-1:0]   N_LAST   = N_W'((1 << AVG_LOG2) - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             w_start;
    logic             w_tick;
    logic             w_add;
    logic [CNT_W-1:0] r_tick_cnt;
    logic [ACC_W-1:0] r_acc;
    logic [N_W-1:0]   r_n;
    logic [7:0]       w_avg;
    logic [7:0]       r_sample_avg;
    logic             r_sample_ready;
    logic             r_overrun;
    logic [2:0]       r_servo_case;

    assign w_tick = (r_tick_cnt == CNT_LAST);
    assign w_add  = (r_state == ACCUM) && active && !rest && w_tick;
    // Shift-by-AVG_LOG2 truncating average taken as a slice of the accumulator.
    assign w_avg  = r_acc[AVG_LOG2 +: 8];

    always_ff @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        case (r_state)
            IDLE: begin
                if (active && !rest) begin
                    w_next  = ACCUM;
                    w_start = 1'b1;
                end
            end
            ACCUM: begin
                if (rest || !active) begin
                    w_next = IDLE;
                end else if (w_tick && (r_n == N_LAST)) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                if (active && !rest) begin
                    w_next  = ACCUM;
                    w_start = 1'b1;
                end else begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset) begin
            r_acc <= '0;
            r_n   <= '0;
        end else if (w_start) begin
            r_acc <= '0;
            r_n   <= '0;
        end else if (w_add) begin
            r_acc <= r_acc + ACC_W'(JA);
            r_n   <= r_n + N_W'(1);
        end
    end

    // A DONE-cycle set takes priority over a coincident ack.
    always_ff @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset) begin
            r_sample_avg   <= '0;
            r_sample_ready <= 1'b0;
            r_overrun      <= 1'b0;
        end else if (r_state == DONE) begin
            r_sample_avg   <= w_avg;
            r_sample_ready <= 1'b1;
            if (r_sample_ready && !cpu_ack) begin
                r_overrun <= 1'b1;
            end
        end else if (cpu_ack && r_sample_ready) begin
            r_sample_ready <= 1'b0;
        end
    end

    always_ff @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset) begin
            r_servo_case <= '0;
        end else if (rest) begin
            r_servo_case <= '0;
        end else if (cpu_case_we) begin
            r_servo_case <= cpu_case;
        end else if ((r_state == DONE) && AUTO_EN) begin
            r_servo_case <= w_avg[7:5];
        end
    end

    assign sample_avg   = r_sample_avg;
    assign sample_ready = r_sample_ready;
    assign overrun      = r_overrun;
    assign servo_case   = r_servo_case;
    assign busy         = (r_state != IDLE);

endmodule

// File: tb/tb_adc_servo_sequencer.sv
// Directed bench for adc_servo_sequencer: table of averaging windows plus
// hand-written rest/arbitration and mid-window async reset sequences.
module tb_adc_servo_sequencer;

    localparam int SP = 4;
    localparam int AL = 2;

    logic       clock = 1'b0;
    logic       ctrl_reset = 1'b1;
    logic [7:0] JA = '0;
    logic       rest = 1'b0;
    logic       active = 1'b0;
    logic       cpu_ack = 1'b0;
    logic       cpu_case_we = 1'b0;
    logic [2:0] cpu_case = '0;
    logic [7:0] sample_avg;
    logic       sample_ready;
    logic       overrun;
    logic [2:0] servo_case;
    logic       busy;

    int tests = 0;
    int fails = 0;
    int tb_cnt = 0;
    bit edge_tick = 1'b0;

    typedef struct {
        logic [7:0] ja0, ja1, ja2, ja3;
        bit         ack_pre;
        bit         ack_done;
        logic [7:0] exp_avg;
        bit         exp_rdy_pre;
        bit         exp_ovr;
        logic [2:0] exp_case;
    } vec_t;

    vec_t vecs[5];

    adc_servo_sequencer #(
        .SAMPLE_PERIOD(SP),
        .AVG_LOG2     (AL),
        .AUTO_EN      (1'b1)
    ) dut (
        .clock       (clock),
        .ctrl_reset  (ctrl_reset),
        .JA          (JA),
        .rest        (rest),
        .active      (active),
        .cpu_ack     (cpu_ack),
        .cpu_case_we (cpu_case_we),
        .cpu_case    (cpu_case),
        .sample_avg  (sample_avg),
        .sample_ready(sample_ready),
        .overrun     (overrun),
        .servo_case  (servo_case),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Inputs change at the negedge; the bench mirrors the free-running tick counter.
    task automatic step();
        @(posedge clock);
        edge_tick = (tb_cnt == SP - 1);
        tb_cnt    = (tb_cnt + 1) % SP;
        @(negedge clock);
    endtask

    task automatic sample_at_tick(input logic [7:0] v);
        for (int k = 0; k < 2 * SP; k++) begin
            JA = (tb_cnt == SP - 1) ? v : 8'h5A;
            step();
            if (edge_tick) break;
        end
        JA = 8'h5A;
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_avg"},   sample_avg, 8'h00);
        chk({nm, "_ready"}, 8'(sample_ready), 8'h00);
        chk({nm, "_ovr"},   8'(overrun), 8'h00);
        chk({nm, "_case"},  8'(servo_case), 8'h00);
        chk({nm, "_busy"},  8'(busy), 8'h00);
    endtask

    task automatic run_window(input vec_t v, input string nm);
        logic [7:0] s[4];
        s = '{v.ja0, v.ja1, v.ja2, v.ja3};
        if (v.ack_pre) begin
            cpu_ack = 1'b1;
            step();
            cpu_ack = 1'b0;
            chk({nm, "_ack_clr"}, 8'(sample_ready), 8'h00);
        end
        for (int i = 0; i < 4; i++) sample_at_tick(s[i]);
        chk({nm, "_rdy_pre"}, 8'(sample_ready), 8'(v.exp_rdy_pre));
        chk({nm, "_busy"}, 8'(busy), 8'h01);
        cpu_ack = v.ack_done;
        step();
        cpu_ack = 1'b0;
        chk({nm, "_avg"},   sample_avg, v.exp_avg);
        chk({nm, "_ready"}, 8'(sample_ready), 8'h01);
        chk({nm, "_ovr"},   8'(overrun), 8'(v.exp_ovr));
        chk({nm, "_case"},  8'(servo_case), 8'(v.exp_case));
    endtask

    initial begin
        vec_t v;

        //           ja0    ja1    ja2    ja3    pre   done  avg    rdy_pre ovr   case
        vecs[0] = '{8'hA0, 8'hA0, 8'hA0, 8'hA0, 1'b0, 1'b0, 8'hA0, 1'b0, 1'b0, 3'd5};
        vecs[1] = '{8'd10, 8'd20, 8'd30, 8'd41, 1'b1, 1'b0, 8'd25, 1'b0, 1'b0, 3'd0};
        vecs[2] = '{8'h60, 8'h60, 8'h60, 8'h60, 1'b0, 1'b1, 8'h60, 1'b1, 1'b0, 3'd3};
        vecs[3] = '{8'h40, 8'h40, 8'h40, 8'h40, 1'b1, 1'b0, 8'h40, 1'b0, 1'b0, 3'd2};
        vecs[4] = '{8'h80, 8'h80, 8'h80, 8'h80, 1'b0, 1'b0, 8'h80, 1'b1, 1'b1, 3'd4};

        JA          = 8'($urandom);
        rest        = 1'($urandom_range(0, 1));
        active      = 1'($urandom_range(0, 1));
        cpu_ack     = 1'($urandom_range(0, 1));
        cpu_case_we = 1'($urandom_range(0, 1));
        cpu_case    = 3'($urandom);
        #1 ctrl_reset = 1'b0;
        #11;
        chk_all_zero("reset");

        @(negedge clock);
        JA = '0; rest = 1'b0; active = 1'b0; cpu_ack = 1'b0; cpu_case_we = 1'b0; cpu_case = '0;
        @(negedge clock);
        ctrl_reset = 1'b1;
        tb_cnt     = 0;
        for (int i = 0; i < 40; i++) step();
        chk_all_zero("idle40");

        active = 1'b1;
        step();
        for (int i = 0; i < 5; i++) run_window(vecs[i], $sformatf("win%0d", i));

        cpu_ack = 1'b1;
        step();
        cpu_ack = 1'b0;
        chk("ack_after_ovr_ready", 8'(sample_ready), 8'h00);
        chk("ack_after_ovr_ovr", 8'(overrun), 8'h01);

        // Rest after two samples drops the partial window and blocks cpu writes.
        sample_at_tick(8'h33);
        sample_at_tick(8'h33);
        rest        = 1'b1;
        cpu_case_we = 1'b1;
        cpu_case    = 3'd6;
        step();
        chk("rest_busy", 8'(busy), 8'h00);
        chk("rest_case", 8'(servo_case), 8'h00);
        for (int i = 0; i < 6; i++) step();
        chk("rest_hold_case", 8'(servo_case), 8'h00);
        chk("rest_hold_ready", 8'(sample_ready), 8'h00);
        rest = 1'b0;
        step();
        cpu_case_we = 1'b0;
        chk("cpu_write_case", 8'(servo_case), 8'h06);
        chk("cpu_write_busy", 8'(busy), 8'h01);
        v = '{8'h20, 8'h20, 8'h20, 8'h20, 1'b0, 1'b0, 8'h20, 1'b0, 1'b1, 3'd1};
        run_window(v, "post_rest");

        // Async reset between edges after three samples of a window.
        sample_at_tick(8'h11);
        sample_at_tick(8'h11);
        sample_at_tick(8'h11);
        #2 ctrl_reset = 1'b0;
        #1;
        chk_all_zero("async_rst");
        @(posedge clock);
        @(negedge clock);
        ctrl_reset = 1'b1;
        tb_cnt     = 0;
        step();
        v = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, 3'd7};
        run_window(v, "after_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/adc_servo_sequencer.md
Name: adc_servo_sequencer

Overview:
Sequences ADC sampling and servo-position selection for the processor's memory-mapped I/O registers. It generates the periodic sample tick and captures 8-bit samples from JA. Each window of 2^AVG_LOG2 samples is averaged and presented with a ready/ack handshake to the processor. It also produces the 3-bit servo case that feeds ServoController's r2case. Position sources are arbitrated by priority: rest override, then processor write, then auto-mapping from the average.

Parameters:
SAMPLE_PERIOD, 500, clock cycles between sample ticks (>=2)
AVG_LOG2, 3, log2 of samples per averaging window (0..4)
AUTO_EN, 1, 1 = servo_case follows each new average when not overridden

Ports:
clock  in  1  system clock, all state on rising edge
ctrl_reset  in  1  asynchronous, active-low reset
JA  in  8  raw ADC sample
rest  in  1  rest request, level
active  in  1  sampling enable, level
cpu_ack  in  1  one-cycle pulse: processor consumed sample_avg
cpu_case_we  in  1  processor write strobe for servo case
cpu_case  in  3  processor servo case value
sample_avg  out  8  latest window average
sample_ready  out  1  new average pending
overrun  out  1  sticky: a pending average was overwritten before ack
servo_case  out  3  case to ServoController r2case
busy  out  1  high when state != IDLE

Behaviour:
- Reset (ctrl_reset=0, async):
  - all outputs 0; state=IDLE; tick counter, accumulator and sample count cleared.
  - Takes effect immediately, including mid-window; the partial window is discarded.
- Tick counter:
  - free-running 0..SAMPLE_PERIOD-1, wraps to 0; runs in every state.
  - tick=1 while count==SAMPLE_PERIOD-1.
- Accumulator: width 8+AVG_LOG2 (no overflow possible). n counts 0..2^AVG_LOG2-1.
- FSM IDLE:
  - if active & ~rest, go to ACCUM with acc=0, n=0.
  - The first sample is taken at the next tick; the counter is not realigned.
- FSM ACCUM:
  - rest=1 or active=0: go to IDLE, discard acc, no ready.
  - else on tick: acc+=JA and n+=1.
  - On the tick where n==2^AVG_LOG2-1, the final sample is added and state goes to DONE.
- FSM DONE (exactly one cycle):
  - sample_avg <= acc>>AVG_LOG2 (truncating); sample_ready <= 1.
  - if sample_ready was already 1 and cpu_ack=0 this cycle: overrun <= 1.
  - next state: ACCUM (acc=0, n=0) if active & ~rest, else IDLE.
- Latency: sample_avg/sample_ready update on the edge following the edge that adds the final sample.
- Handshake:
  - cpu_ack with sample_ready=1 clears sample_ready on the next edge.
  - cpu_ack with sample_ready=0 is ignored.
  - If cpu_ack coincides with DONE: set wins; sample_ready stays 1; no overrun.
- overrun is cleared only by reset.
- servo_case, evaluated each edge in priority order:
  1. rest=1: servo_case <= 0.
  2. else cpu_case_we=1: servo_case <= cpu_case.
  3. else state==DONE and AUTO_EN: servo_case <= new average [7:5].
  4. else hold.
  - A cpu write during rest is dropped, not deferred.
- busy is combinational from state.
- JA is sampled only on tick edges; values between ticks are ignored.

Test Plan:
Bench uses SAMPLE_PERIOD=4, AVG_LOG2=2, AUTO_EN=1.
1. Reset:
   - Assert ctrl_reset=0 with random inputs -> all outputs 0, busy=0.
   - Release, active=0 for 40 cycles -> outputs stay 0.
2. Constant input: active=1, rest=0, JA=8'hA0 held.
   - After 4 ticks -> sample_avg=8'hA0, sample_ready=1, servo_case=3'd5, overrun=0.
   - Ready asserts one edge after the 4th tick edge.
3. Averaging: JA=10,20,30,41 on successive ticks -> sum 101, sample_avg=8'd25, servo_case=3'd0.
4. Handshake and overrun:
   - No cpu_ack across two windows (JA 8'h40, then 8'h80) -> overrun=1, sample_avg=8'h80.
   - cpu_ack pulse -> sample_ready=0; overrun remains 1.
   - cpu_ack in the DONE cycle of a window -> sample_ready stays 1, overrun stays 0.
5. Rest and write arbitration:
   - rest=1 after 2 samples -> IDLE next edge, busy=0, servo_case=0, no ready.
   - cpu_case_we with 3'd6 during rest -> ignored.
   - After rest=0, cpu_case_we with 3'd6 -> servo_case=6.
   - Next DONE with JA=8'h20 -> servo_case=1.
6. Async reset mid-ACCUM (after 3 samples, between clock edges) -> outputs 0 immediately.
   - After release, the first full window of JA=8'hFF gives sample_avg=8'hFF; no stale partial sum.
